// File: rtl/pla_exp_stream_pkg.sv
// pla_exp_pkg: shared widths, types and domain helpers
// for the streaming piecewise-linear exp datapath.
package pla_exp_pkg;

   localparam int PLA_W     = 32;
   localparam int PLA_Q     = 26;
   localparam int PLA_LANES = 4;

   typedef logic signed [PLA_W-1:0]   coef_t;
   typedef logic signed [2*PLA_W-1:0] prod_t;

   typedef struct packed {
      logic                 valid;
      logic                 round;
      logic [PLA_LANES-1:0] mask;
   } beat_ctl_t;

   function automatic longint xmin(
      input int xmin_int,
      input int q
   );
      return longint'(xmin_int) <<< q;
   endfunction

   function automatic longint xmax(
      input int xmin_int,
      input int nseg,
      input int seg_shift,
      input int q
   );
      return xmin(xmin_int, q)
           + (longint'(nseg) <<< seg_shift);
   endfunction

endpackage

// File: rtl/pla_exp_stream_if.sv
// pla_exp_stream_if: beat-level valid/ready bundle
// between the row-max subtractor and the softmax sum.
interface pla_exp_stream_if
   import pla_exp_pkg::*;
#(
   parameter int LANES = PLA_LANES,
   parameter int W     = PLA_W
);
   logic               in_valid;
   logic               in_ready;
   logic [LANES*W-1:0] in_data;
   logic [LANES-1:0]   in_mask;
   logic               in_round;
   logic               out_valid;
   logic               out_ready;
   logic [LANES*W-1:0] out_data;
   logic [LANES-1:0]   out_clamp;
   logic [LANES-1:0]   out_sat;

   modport master (
      output in_valid, in_data, in_mask,
      output in_round, out_ready,
      input  in_ready, out_valid, out_data,
      input  out_clamp, out_sat
   );

   modport slave (
      input  in_valid, in_data, in_mask,
      input  in_round, out_ready,
      output in_ready, out_valid, out_data,
      output out_clamp, out_sat
   );
endinterface

// File: rtl/pla_exp_stream_lane.sv
// pla_exp_lane: one lane of clamp/index, coefficient
// latch, multiply and round/add/saturate (S0..S3).
module pla_exp_lane
   import pla_exp_pkg::*;
#(
   parameter int W         = PLA_W,
   parameter int Q         = PLA_Q,
   parameter int NSEG      = 32,
   parameter int SEG_SHIFT = 26,
   parameter int XMIN_INT  = -16,
   localparam int IW       = $clog2(NSEG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                adv,
   input  logic signed [W-1:0] x,
   output logic [IW-1:0]       idx,
   input  logic signed [W-1:0] w_rd,
   input  logic signed [W-1:0] b_rd,
   input  logic                rnd,
   input  logic                act,
   output logic [W-1:0]        y,
   output logic                clamp,
   output logic                sat
);
   typedef logic signed [W-1:0]   word_t;
   typedef logic signed [2*W-1:0] wide_t;

   localparam longint XMN_L =
      xmin(XMIN_INT, Q);
   localparam longint XMX_L =
      xmax(XMIN_INT, NSEG, SEG_SHIFT, Q);
   localparam word_t XMN  = word_t'(XMN_L);
   localparam word_t XMX  = word_t'(XMX_L);
   localparam wide_t HALF = wide_t'(1) <<< (Q-1);
   localparam wide_t YMAX =
      (wide_t'(1) <<< (W-1)) - wide_t'(1);

   logic          lo, hi;
   word_t         xc;
   logic [W-1:0]  delta, seg;
   logic [IW-1:0] idx_c;

   always_comb begin
      lo    = x < XMN;
      hi    = x > XMX;
      xc    = lo ? XMN : (hi ? XMX : x);
      delta = xc - XMN;
      seg   = delta >> SEG_SHIFT;
      // x == XMAX lands one past the table
      idx_c = (seg >= W'(NSEG))
            ? IW'(NSEG-1) : seg[IW-1:0];
   end

   word_t x0, x1, w1, b1, b2;
   logic  c0, c1, c2;
   wide_t p2;

   wide_t        rnd_add, sc, sum;
   logic [W-1:0] y_c;
   logic         cl_c, sat_c;

   always_comb begin
      rnd_add = rnd ? HALF : wide_t'(0);
      sc      = (p2 + rnd_add) >>> Q;
      sum     = sc + wide_t'(b2);
      y_c     = sum[W-1:0];
      sat_c   = 1'b0;
      cl_c    = c2;
      if (sum < 0) begin
         y_c   = '0;
         sat_c = 1'b1;
      end else if (sum > YMAX) begin
         y_c   = YMAX[W-1:0];
         sat_c = 1'b1;
      end
      if (!act) begin
         y_c   = '0;
         sat_c = 1'b0;
         cl_c  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x0    <= '0;
         idx   <= '0;
         c0    <= 1'b0;
         x1    <= '0;
         w1    <= '0;
         b1    <= '0;
         c1    <= 1'b0;
         p2    <= '0;
         b2    <= '0;
         c2    <= 1'b0;
         y     <= '0;
         clamp <= 1'b0;
         sat   <= 1'b0;
      end else if (adv) begin
         x0    <= xc;
         idx   <= idx_c;
         c0    <= lo | hi;
         x1    <= x0;
         w1    <= w_rd;
         b1    <= b_rd;
         c1    <= c0;
         p2    <= wide_t'(w1) * wide_t'(x1);
         b2    <= b1;
         c2    <= c1;
         y     <= y_c;
         clamp <= cl_c;
         sat   <= sat_c;
      end
   end
endmodule

// File: rtl/pla_exp_stream.sv
// pla_exp_stream: 4-stage multi-lane PLA exp with a
// shared writable coefficient table and one stall enable.
module pla_exp_stream
   import pla_exp_pkg::*;
#(
   parameter int LANES     = PLA_LANES,
   parameter int W         = PLA_W,
   parameter int Q         = PLA_Q,
   parameter int NSEG      = 32,
   parameter int SEG_SHIFT = 26,
   parameter int XMIN_INT  = -16,
   localparam int IW       = $clog2(NSEG)
) (
   input  logic          clk,
   input  logic          rst,
   pla_exp_stream_if.slave s,
   output logic          busy,
   input  logic          coef_we,
   input  logic [IW-1:0] coef_addr,
   input  logic [W-1:0]  coef_w,
   input  logic [W-1:0]  coef_b
);
   logic         adv, ov;
   beat_ctl_t    c_in, c0, c1, c2;
   logic [2*W-1:0] tbl [NSEG];
   logic [LANES*W-1:0] y;
   logic [LANES-1:0]   cl, st;

   assign adv         = !ov || s.out_ready;
   assign s.in_ready  = adv;
   assign s.out_valid = ov;
   assign s.out_data  = y;
   assign s.out_clamp = cl;
   assign s.out_sat   = st;
   assign busy = c0.valid | c1.valid
               | c2.valid | ov;

   always_comb begin
      c_in       = '0;
      c_in.valid = s.in_valid;
      c_in.round = s.in_round;
      c_in.mask[LANES-1:0] = s.in_mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c0 <= '0;
         c1 <= '0;
         c2 <= '0;
         ov <= 1'b0;
      end else if (adv) begin
         c0 <= c_in;
         c1 <= c0;
         c2 <= c1;
         ov <= c2.valid;
      end
   end

   // not reset: coefficients survive a pipeline flush
   always_ff @(posedge clk) begin
      if (coef_we)
         tbl[coef_addr] <= {coef_w, coef_b};
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [IW-1:0]  idx;
      logic [2*W-1:0] ent;

      assign ent = tbl[idx];

      pla_exp_lane #(
         .W(W), .Q(Q), .NSEG(NSEG),
         .SEG_SHIFT(SEG_SHIFT),
         .XMIN_INT(XMIN_INT)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .adv   (adv),
         .x     (s.in_data[k*W +: W]),
         .idx   (idx),
         .w_rd  (ent[2*W-1:W]),
         .b_rd  (ent[W-1:0]),
         .rnd   (c2.round),
         .act   (c2.mask[k]),
         .y     (y[k*W +: W]),
         .clamp (cl[k]),
         .sat   (st[k])
      );
   end
endmodule

// File: tb/tb_pla_exp_stream.sv
// tb_pla_exp_stream: vector table, hand sequences and a
// randomized stream against an arithmetic reference model.
module tb_pla_exp_stream;
   import pla_exp_pkg::*;

   localparam int NRND = 300;
   localparam longint SEGW = longint'(1) << 26;
   localparam longint XLO  = -16 * SEGW;
   localparam longint XHI  = XLO + 32 * SEGW;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy;
   logic        coef_we;
   logic [4:0]  coef_addr;
   logic [31:0] coef_w, coef_b;

   pla_exp_stream_if sif ();

   pla_exp_stream dut (
      .clk       (clk),
      .rst       (rst),
      .s         (sif),
      .busy      (busy),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_w    (coef_w),
      .coef_b    (coef_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] y;
      logic [3:0]   c;
      logic [3:0]   s;
      int           cyc;
   } exp_t;

   typedef struct {
      bit           we;
      int           a;
      logic [31:0]  w;
      logic [31:0]  b;
      logic [127:0] x;
      logic [3:0]   m;
      bit           r;
      logic [127:0] y;
      logic [3:0]   c;
      logic [3:0]   s;
   } vec_t;

   coef_t tw [32];
   coef_t tbv [32];
   exp_t  eq [$];
   exp_t  me;

   int cyc = 0, n_acc = 0, n_out = 0;
   int errs = 0, checks = 0;
   int last_lat = 0;
   logic [127:0] last_y;
   logic [3:0]   last_c, last_s;

   function automatic exp_t model(
      input logic [127:0] x,
      input logic [3:0]   m,
      input bit           r
   );
      exp_t   e;
      longint xv, xc, p, sum;
      int     idx;
      e.y = '0; e.c = '0; e.s = '0; e.cyc = 0;
      for (int k = 0; k < 4; k++) begin
         xv = longint'($signed(x[k*32 +: 32]));
         xc = (xv < XLO) ? XLO
            : ((xv > XHI) ? XHI : xv);
         idx = int'((xc - XLO) / SEGW);
         if (idx > 31) idx = 31;
         p = longint'(tw[idx]) * xc;
         if (r) p = p + (longint'(1) << 25);
         p   = p >>> 26;
         sum = p + longint'(tbv[idx]);
         if (m[k]) begin
            e.c[k] = (xc != xv);
            if (sum < 0) begin
               e.s[k] = 1'b1;
            end else if (sum > 2147483647) begin
               e.s[k] = 1'b1;
               e.y[k*32 +: 32] = 32'h7FFF_FFFF;
            end else begin
               e.y[k*32 +: 32] = sum[31:0];
            end
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         eq.delete();
      end else begin
         if (sif.in_valid && sif.in_ready) begin
            me = model(sif.in_data, sif.in_mask,
                       sif.in_round);
            me.cyc = cyc;
            eq.push_back(me);
            n_acc++;
         end
         if (sif.out_valid && sif.out_ready) begin
            n_out++;
            last_y = sif.out_data;
            last_c = sif.out_clamp;
            last_s = sif.out_sat;
            checks++;
            if (eq.size() == 0) begin
               errs++;
               $display("FAIL sb_extra: got %h",
                        sif.out_data);
            end else begin
               me = eq.pop_front();
               last_lat = cyc - me.cyc;
               if ({last_y, last_c, last_s} !==
                   {me.y, me.c, me.s}) begin
                  errs++;
                  $display("FAIL sb: got %h/%b/%b want %h/%b/%b",
                           last_y, last_c, last_s,
                           me.y, me.c, me.s);
               end
            end
         end
      end
   end

   task automatic chk(
      input string        nm,
      input logic [159:0] act,
      input logic [159:0] exp
   );
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h",
                  nm, act, exp);
      end
   endtask

   task automatic write_coef(
      input int          a,
      input logic [31:0] w,
      input logic [31:0] b
   );
      coef_we   = 1'b1;
      coef_addr = 5'(a);
      coef_w    = w;
      coef_b    = b;
      tw[a]     = w;
      tbv[a]    = b;
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   task automatic load_default();
      for (int i = 0; i < 32; i++)
         write_coef(i, 32'h0, 32'(i) << 26);
   endtask

   task automatic send_beat(
      input logic [127:0] x,
      input logic [3:0]   m,
      input bit           r
   );
      int a0 = n_acc;
      int c  = 0;
      sif.in_data  = x;
      sif.in_mask  = m;
      sif.in_round = r;
      sif.in_valid = 1'b1;
      while (n_acc == a0 && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      sif.in_valid = 1'b0;
      if (n_acc == a0) begin
         checks++; errs++;
         $display("FAIL send: accepted 0 want 1");
      end
   endtask

   task automatic wait_out(
      input int target,
      input int bound
   );
      int c = 0;
      while (n_out < target && c < bound) begin
         @(posedge clk); #1;
         c++;
      end
      checks++;
      if (n_out < target) begin
         errs++;
         $display("FAIL wait_out: outputs %0d want %0d",
                  n_out, target);
      end
   endtask

   task automatic drain(input int bound);
      int c = 0;
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b1;
      while ((eq.size() != 0 || busy) && c < bound) begin
         @(posedge clk); #1;
         c++;
      end
      checks++;
      if (eq.size() != 0 || busy) begin
         errs++;
         $display("FAIL drain: pending %0d want 0",
                  eq.size());
      end
   endtask

   function automatic logic [127:0] rnd_x();
      logic [127:0] v;
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(0, 3) == 0)
            v[k*32 +: 32] = $urandom;
         else
            v[k*32 +: 32] =
               32'($urandom_range(0, 32'h8000_0000))
               - 32'h4000_0000;
      end
      return v;
   endfunction

   localparam logic [127:0] X1 = {
      32'h4000_0000, 32'hB000_0000,
      32'hFC00_0000, 32'h0000_0000};

   vec_t vt [6];
   int   a0, o0, k, stall, ovs, sent;
   logic [135:0] hold;

   initial begin
      vt[0] = '{we:0, a:0, w:0, b:0, x:X1,
         m:4'hF, r:0,
         y:{32'h7C00_0000, 32'h0,
            32'h3C00_0000, 32'h4000_0000},
         c:4'b0100, s:4'b0000};
      vt[1] = '{we:0, a:0, w:0, b:0, x:X1,
         m:4'b0101, r:0,
         y:{32'h0, 32'h0, 32'h0, 32'h4000_0000},
         c:4'b0100, s:4'b0000};
      vt[2] = '{we:1, a:16, w:32'h1, b:32'h0,
         x:{4{32'h0200_0000}}, m:4'hF, r:0,
         y:{4{32'h0}}, c:4'b0, s:4'b0};
      vt[3] = '{we:0, a:0, w:0, b:0,
         x:{4{32'h0200_0000}}, m:4'hF, r:1,
         y:{4{32'h1}}, c:4'b0, s:4'b0};
      vt[4] = '{we:1, a:17, w:32'h0400_0000,
         b:32'h7FFF_FFFF,
         x:{4{32'h0400_0000}}, m:4'hF, r:0,
         y:{4{32'h7FFF_FFFF}}, c:4'b0, s:4'hF};
      vt[5] = '{we:1, a:16, w:32'h0,
         b:32'hF800_0000,
         x:{4{32'h0}}, m:4'hF, r:0,
         y:{4{32'h0}}, c:4'b0, s:4'hF};

      sif.in_valid  = 1'b0;
      sif.in_data   = '0;
      sif.in_mask   = '0;
      sif.in_round  = 1'b0;
      sif.out_ready = 1'b1;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_w    = '0;
      coef_b    = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_out_valid", sif.out_valid, 0);
      chk("rst_out_data", sif.out_data, 0);
      chk("rst_out_clamp", sif.out_clamp, 0);
      chk("rst_out_sat", sif.out_sat, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", sif.in_ready, 1);

      load_default();
      for (int i = 0; i < 6; i++) begin
         if (vt[i].we)
            write_coef(vt[i].a, vt[i].w, vt[i].b);
         o0 = n_out;
         send_beat(vt[i].x, vt[i].m, vt[i].r);
         wait_out(o0 + 1, 20);
         chk($sformatf("v%0d_data", i),
             last_y, vt[i].y);
         chk($sformatf("v%0d_clamp", i),
             last_c, vt[i].c);
         chk($sformatf("v%0d_sat", i),
             last_s, vt[i].s);
         chk($sformatf("v%0d_lat", i),
             last_lat, 4);
      end

      load_default();
      chk("busy_idle", busy, 0);
      send_beat(X1, 4'b0101, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("busy_c%0d", i), busy, 1);
         chk($sformatf("ov_c%0d", i),
             sif.out_valid, (i == 3));
         @(posedge clk); #1;
      end
      chk("busy_done", busy, 0);

      sif.out_ready = 1'b0;
      k = 0; stall = 0;
      a0 = n_acc; o0 = n_out;
      sif.in_data  = rnd_x();
      sif.in_mask  = 4'hF;
      sif.in_round = 1'b0;
      sif.in_valid = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (sif.in_valid && n_acc != a0) begin
            a0 = n_acc;
            k++;
            if (k < 8) begin
               sif.in_data  = rnd_x();
               sif.in_round = k[0];
            end else begin
               sif.in_valid = 1'b0;
            end
         end
         if (sif.out_valid && !sif.out_ready) begin
            if (stall == 0)
               hold = {sif.out_data, sif.out_clamp,
                       sif.out_sat};
            else
               chk("bp_stable",
                   {sif.out_data, sif.out_clamp,
                    sif.out_sat}, hold);
            chk("bp_in_ready", sif.in_ready, 0);
            stall++;
            if (stall == 10) sif.out_ready = 1'b1;
         end
         if (k == 8 && sif.out_ready) break;
      end
      drain(100);
      chk("bp_count", n_out - o0, 8);

      o0 = n_out;
      a0 = n_acc;
      sif.in_data  = X1;
      sif.in_mask  = 4'hF;
      sif.in_round = 1'b0;
      sif.in_valid = 1'b1;
      for (int c = 0; c < 20 && n_acc - a0 < 3; c++) begin
         @(posedge clk); #1;
      end
      sif.in_valid = 1'b0;
      chk("mid_busy_pre", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_busy", busy, 0);
      chk("mid_in_ready", sif.in_ready, 1);
      ovs = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (sif.out_valid) ovs++;
      end
      chk("mid_no_out", ovs, 0);
      chk("mid_no_emit", n_out - o0, 0);
      send_beat(X1, 4'hF, 1'b0);
      wait_out(o0 + 1, 20);
      chk("mid_data", last_y, vt[0].y);
      chk("mid_clamp", last_c, vt[0].c);

      for (int i = 0; i < 32; i++) begin
         if (i % 2 == 0)
            write_coef(i, $urandom, $urandom);
         else
            write_coef(i,
               32'($urandom_range(0, 32'h0800_0000))
               - 32'h0400_0000, $urandom);
      end
      sent = 0;
      a0 = n_acc;
      sif.in_valid = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         @(posedge clk); #1;
         if (sif.in_valid && n_acc != a0)
            sif.in_valid = 1'b0;
         a0 = n_acc;
         if (!sif.in_valid && sent < NRND &&
             $urandom_range(0, 3) != 0) begin
            sif.in_data  = rnd_x();
            sif.in_mask  = 4'($urandom);
            sif.in_round = 1'($urandom);
            sif.in_valid = 1'b1;
            sent++;
         end
         sif.out_ready = ($urandom_range(0, 3) != 0);
         if (sent == NRND && !sif.in_valid) break;
      end
      drain(200);
      chk("rnd_accepted", sent, NRND);

      $display("Result: errors=%0d of %0d checks",
               errs, checks);
      $finish;
   end
endmodule
